// File: rtl/tone_voice_pkg.sv
// rtl/tone_voice_pkg.sv - shared state encodings and constants for the tone voice
package tone_voice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DECAY = 2'd2
  } state_t;

  // Offset-binary bias of the sinewaver output and of the DAC input.
  localparam logic [15:0] WAVE_BIAS = 16'h8000;

endpackage

// File: rtl/tone_voice_sigma_delta_dac_16.sv
// rtl/tone_voice_sigma_delta_dac_16.sv - first-order sigma-delta DAC, 16-bit unsigned input
module sigma_delta_dac_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  output logic        out
);

  logic [15:0] acc;
  logic [16:0] sum;

  assign sum = {1'b0, acc} + {1'b0, in};

  // The carry of each accumulation is the output bit; its density equals in/65536.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 16'd0;
      out <= 1'b0;
    end else begin
      acc <= sum[15:0];
      out <= sum[16];
    end
  end

endmodule

// File: rtl/tone_voice.sv
// rtl/tone_voice.sv - sound-effect voice: pitch divider, hold/decay envelope, volume scaling, sigma-delta out
module tone_voice
  import tone_voice_pkg::*;
#(
  parameter logic [15:0] ENV_TICK   = 16'd50000,
  parameter logic [7:0]  DECAY_STEP = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] period,
  input  logic [7:0]  hold,
  input  logic [15:0] wave,
  output logic        trigger,
  output logic        busy,
  output logic        audio
);

  state_t      state, state_nxt;
  logic [11:0] per_l, divcnt;
  logic [7:0]  hold_cnt, vol, vol_dec;
  logic [15:0] tickcnt;
  logic        active, env_tick, div_hit;
  logic signed [24:0] s_x, v_x;
  logic [15:0] scaled;

  always_comb begin
    active    = (state != ST_IDLE);
    env_tick  = active && (tickcnt == ENV_TICK - 16'd1);
    div_hit   = (divcnt == per_l);
    vol_dec   = (vol > DECAY_STEP) ? vol - DECAY_STEP : 8'd0;
    state_nxt = state;
    if (start) begin
      state_nxt = ST_HOLD;
    end else begin
      case (state)
        ST_HOLD:  if (env_tick && hold_cnt == 8'd0) state_nxt = ST_DECAY;
        ST_DECAY: if (env_tick && vol_dec == 8'd0) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      trigger  <= 1'b0;
      per_l    <= 12'd0;
      hold_cnt <= 8'd0;
      vol      <= 8'd0;
      divcnt   <= 12'd0;
      tickcnt  <= 16'd0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != ST_IDLE);
      // A start or the final decay tick suppresses the pulse so no stray trigger escapes.
      trigger <= !start && active && (state_nxt != ST_IDLE) && div_hit;
      if (start) begin
        per_l    <= period;
        hold_cnt <= hold;
        vol      <= 8'd255;
        divcnt   <= 12'd0;
        tickcnt  <= 16'd0;
      end else if (active) begin
        divcnt  <= div_hit ? 12'd0 : divcnt + 12'd1;
        tickcnt <= env_tick ? 16'd0 : tickcnt + 16'd1;
        if (env_tick) begin
          if (state == ST_HOLD && hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
          if (state == ST_DECAY) vol <= vol_dec;
        end
      end else begin
        vol     <= 8'd0;
        divcnt  <= 12'd0;
        tickcnt <= 16'd0;
      end
    end
  end

  always_comb begin
    s_x = 25'(signed'(wave ^ WAVE_BIAS));
    v_x = signed'({17'd0, vol});
  end

  // Arithmetic shift keeps the floor rounding of the signed product.
  always_ff @(posedge clk) begin
    if (rst) scaled <= 16'd0;
    else     scaled <= 16'((s_x * v_x) >>> 8);
  end

  sigma_delta_dac_16 u_dac (
    .clk (clk),
    .rst (rst),
    .in  (scaled ^ WAVE_BIAS),
    .out (audio)
  );

endmodule

// File: tb/tb_tone_voice.sv
// tb/tb_tone_voice.sv - directed self-checking bench for tone_voice
module tb_tone_voice;
  import tone_voice_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] period;
  logic [7:0]  hold;
  logic [15:0] wave;
  logic        trigger, busy, audio;
  int          checks = 0;
  int          failures = 0;
  int          ones;
  int          ev;
  logic        prev;

  always #5 clk = ~clk;

  tone_voice #(.ENV_TICK(16'd4), .DECAY_STEP(8'd4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .period  (period),
    .hold    (hold),
    .wave    (wave),
    .trigger (trigger),
    .busy    (busy),
    .audio   (audio)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; period = 12'd0; hold = 8'd0; wave = 16'h8000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_trigger", 32'(trigger), 32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_audio",   32'(audio),   32'd0);
      check("rst_state",   32'(dut.state), 32'(ST_IDLE));
    end

    rst = 1'b0; start = 1'b0; wave = 16'h7123;
    for (int i = 0; i < 16; i++) begin
      step();
      check("idle_audio_alt", 32'(audio), 32'(i % 2));
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_trigger", 32'(trigger), 32'd0);
    end

    // period=3, hold=1
    period = 12'd3; hold = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 270; k++) begin
      check("main_trigger", 32'(trigger), 32'(k >= 5 && k <= 264 && (k - 5) % 4 == 0));
      check("main_busy", 32'(busy), 32'(k <= 264));
      if (k <= 12) ev = 255;
      else ev = 255 - 4 * ((k - 13) / 4 + 1);
      if (ev < 0) ev = 0;
      check("main_vol", 32'(dut.vol), 32'(ev));
      if (k == 265) check("main_idle_state", 32'(dut.state), 32'(ST_IDLE));
      step();
    end

    // period=0: trigger every cycle until idle
    period = 12'd0; hold = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 265; k++) begin
      check("p0_trigger", 32'(trigger), 32'(k >= 2 && k <= 260));
      check("p0_busy", 32'(busy), 32'(k <= 260));
      step();
    end

    // retrigger when vol reaches 127
    period = 12'd3; hold = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (132) step();
    check("retrig_vol127", 32'(dut.vol), 32'd127);
    period = 12'd7; hold = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      check("retrig_trigger", 32'(trigger), 32'(k >= 9 && (k - 9) % 8 == 0));
      if (k <= 20) check("retrig_vol", 32'(dut.vol), 32'd255);
      step();
    end
    for (int i = 0; i < 2000 && busy; i++) step();
    check("retrig_done_busy", 32'(busy), 32'd0);
    check("retrig_done_vol", 32'(dut.vol), 32'd0);

    // silence after an effect: 50% duty regardless of wave
    wave = 16'h1234;
    repeat (4) step();
    ones = 0;
    prev = audio;
    for (int i = 0; i < 1000; i++) begin
      step();
      check("silence_alt", 32'(audio), 32'(!prev));
      prev = audio;
      ones += int'(audio);
    end
    check("silence_ones", 32'(ones), 32'd500);

    // full-volume DAC duty, kept at vol=255 by periodic restarts
    wave = 16'hC000; period = 12'd0; hold = 8'd255; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("dac_scaled", 32'(dut.scaled), 32'h3FC0);
    ones = 0;
    for (int i = 0; i < 65536; i++) begin
      start = (i % 256 == 255);
      step();
      ones += int'(audio);
    end
    start = 1'b0;
    check("dac_ones", 32'(ones), 32'd49088);
    check("dac_vol", 32'(dut.vol), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
